// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
//   DATA_BITS_DEF     : default UART word width
//   tx_feeder_state_t : transmit feeder state encoding
package uart_pkg;

    localparam int unsigned DATA_BITS_DEF = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a combinational head read.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push/wdata : write a word (ignored while full)
//   pop        : drop the head word (ignored while empty)
//   rdata      : current head word, read from the registered read pointer
//   count      : occupancy; full/empty decoded from it
module uart_sync_fifo #(
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_BITS-1:0]     wdata,
    output logic [DATA_BITS-1:0]     rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == CNT_W'(0));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array carries no reset; stale contents are never read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH since it is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer words and hands them one at a time to a UART transmitter.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   in_data/in_valid  : producer word, accepted when in_ready is high
//   in_ready          : buffer has room (equals !full)
//   tx_data/tx_req    : word and one-cycle request to the UART
//   tx_busy           : UART busy; a rise after a request confirms the word
//   count/empty/full  : buffer occupancy
//   timeout           : one-cycle pulse when the UART never acknowledged
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEF,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BUSY_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_BITS-1:0]     in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_BITS-1:0]     tx_data,
    output logic                     tx_req,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     timeout
);

    localparam int unsigned WAIT_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

    tx_feeder_state_t     state;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_push;
    logic                 fifo_pop;

    assign in_ready  = !full;
    assign fifo_push = in_valid && in_ready;
    // The head is only retired once the UART shows it has taken the word.
    assign fifo_pop  = (state == WAIT_BUSY) && tx_busy;

    uart_sync_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Request sequencer: load head, pulse request, wait for busy rise/fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            tx_data  <= '0;
            tx_req   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            tx_req  <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        tx_data <= head;
                        tx_req  <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (wait_cnt == WAIT_W'(BUSY_WAIT - 1)) begin
                        // No acknowledge: keep the word buffered and retry.
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed scenarios with a
// queue-based occupancy model and a simple UART responder.
module tb_uart_tx_feeder;

    localparam int DEPTH     = 16;
    localparam int BUSY_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] tx_data;
    logic        tx_req;
    logic        tx_busy;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        timeout;

    uart_tx_feeder #(
        .DATA_BITS (32),
        .DEPTH     (DEPTH),
        .BUSY_WAIT (BUSY_WAIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .tx_busy  (tx_busy),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: buffered words, request tracking, UART responder.
    logic [31:0] q[$];
    logic [31:0] pop_log[$];
    logic [31:0] cur = '0;
    int          since = -1;
    bit          hold = 1'b0;
    bit          popped = 1'b0;
    bit          exp_to = 1'b0;
    bit          last_acc = 1'b0;
    bit          uart_en = 1'b0;
    int          resp_wait = 0;
    int          busy_left = 0;
    int          busy_len = 10;
    int          nreq = 0;
    int          npop = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: update the model at the edge, then check and respond.
    task automatic step();
        bit pop_now;
        bit to_now;
        logic [31:0] head;
        @(posedge clk);
        pop_now  = 1'b0;
        to_now   = 1'b0;
        last_acc = 1'b0;
        if (reset) begin
            q.delete();
            since  = -1;
            hold   = 1'b0;
            popped = 1'b0;
        end else begin
            if (popped && !tx_busy) begin
                popped = 1'b0;
                hold   = 1'b0;
            end
            if (since >= 0) begin
                since++;
                // busy is only looked at from the second edge after a request
                if (since >= 2 && tx_busy) begin
                    pop_now = 1'b1;
                    since   = -1;
                    popped  = 1'b1;
                end else if (since == BUSY_WAIT + 1) begin
                    to_now = 1'b1;
                    since  = -1;
                    hold   = 1'b0;
                end
            end
            last_acc = in_valid && (q.size() < DEPTH);
            if (pop_now && q.size() > 0) begin
                head = q.pop_front();
                pop_log.push_back(cur);
                npop++;
            end
            if (last_acc) q.push_back(in_data);
        end
        exp_to = to_now;
        #1;
        chk("count", 32'(count), q.size());
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("timeout", 32'(timeout), 32'(exp_to));
        if (hold) chk("tx_data_hold", tx_data, cur);
        if (resp_wait > 0) begin
            resp_wait--;
            if (resp_wait == 0) begin
                tx_busy   = 1'b1;
                busy_left = busy_len;
            end
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
        end
        if (tx_req) begin
            nreq++;
            chk("tx_req_nonempty", 32'(q.size() > 0), 1);
            if (q.size() > 0) chk("tx_req_data", tx_data, q[0]);
            cur   = tx_data;
            hold  = 1'b1;
            since = 0;
            if (uart_en) resp_wait = 1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n0;
        int k;
        int idx;
        int base;
        logic [31:0] w [4];

        reset = 1'b1; in_valid = 1'b0; in_data = '0; tx_busy = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_tx_req", 32'(tx_req), 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        step();

        // Single word with a responsive UART
        uart_en = 1'b1; busy_len = 10; n0 = nreq;
        in_valid = 1'b1; in_data = 32'hDEADBEEF; step(); in_valid = 1'b0;
        chk("single_no_req_yet", 32'(tx_req), 0);
        step();
        chk("single_req", 32'(tx_req), 1);
        chk("single_data", tx_data, 32'hDEADBEEF);
        step();
        chk("single_req_pulse", 32'(tx_req), 0);
        run(25);
        chk("single_req_count", nreq - n0, 1);
        chk("single_sent", pop_log[$], 32'hDEADBEEF);

        // Timeout and retry of the same word
        uart_en = 1'b0; n0 = nreq;
        in_valid = 1'b1; in_data = 32'h12345678; step(); in_valid = 1'b0;
        step();
        chk("to_first_req", 32'(tx_req), 1);
        k = 0;
        do begin step(); k++; end while (!timeout && k < 20);
        // the REQ cycle, then BUSY_WAIT unanswered sampling cycles
        chk("timeout_latency", k, BUSY_WAIT + 1);
        chk("timeout_count", 32'(count), 1);
        uart_en = 1'b1;
        step();
        chk("retry_req", 32'(tx_req), 1);
        chk("retry_data", tx_data, 32'h12345678);
        chk("retry_nreq", nreq - n0, 2);
        run(25);
        chk("retry_sent", pop_log[$], 32'h12345678);
        chk("retry_empty", 32'(empty), 1);

        // Push on the same edge as the pop with one word buffered
        in_valid = 1'b1; in_data = 32'h11111111; step(); in_valid = 1'b0;
        step(); step();
        in_valid = 1'b1; in_data = 32'hA5A5A5A5; step(); in_valid = 1'b0;
        chk("pp_count", 32'(count), 1);
        run(40);
        chk("pp_order0", pop_log[$-1], 32'h11111111);
        chk("pp_order1", pop_log[$], 32'hA5A5A5A5);

        // Burst to full with a silent UART, then drain in order
        uart_en = 1'b0; base = pop_log.size(); idx = 0;
        in_valid = 1'b1;
        for (int c = 0; c < DEPTH + 1; c++) begin
            in_data = 32'(idx);
            step();
            if (last_acc) idx++;
        end
        chk("burst_full", 32'(full), 1);
        chk("burst_in_ready", 32'(in_ready), 0);
        chk("burst_count", 32'(count), 16);
        in_data = 32'd16;
        run(3);
        chk("burst_held_off", 32'(count), 16);
        uart_en = 1'b1; k = 0;
        do begin step(); k++; end while (!last_acc && k < 300);
        chk("burst_accept_bound", 32'(k < 300), 1);
        chk("burst_refill", 32'(count), 16);
        in_valid = 1'b0; k = 0;
        while (!(empty && hold == 1'b0 && !tx_busy) && k < 800) begin step(); k++; end
        chk("drain_bound", 32'(k < 800), 1);
        for (int i = 0; i < 17; i++) chk("burst_order", pop_log[base + i], 32'(i));

        // Random words through the UART responder
        busy_len = int'($urandom_range(1, 12)); base = pop_log.size();
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom();
            in_valid = 1'b1; in_data = w[i]; step(); in_valid = 1'b0;
            run(int'($urandom_range(0, 3)));
        end
        k = 0;
        while (!(empty && hold == 1'b0 && !tx_busy) && k < 300) begin step(); k++; end
        chk("loop_bound", 32'(k < 300), 1);
        for (int i = 0; i < 4; i++) chk("loop_word", pop_log[base + i], w[i]);

        // Reset while a word is in flight
        busy_len = 10; uart_en = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin in_data = 32'hC0000000 + 32'(i); step(); end
        in_valid = 1'b0; k = 0;
        while (!(popped && tx_busy) && k < 100) begin step(); k++; end
        chk("rst_mid_reach", 32'(k < 100), 1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_mid_count", 32'(count), 0);
        chk("rst_mid_empty", 32'(empty), 1);
        chk("rst_mid_tx_req", 32'(tx_req), 0);
        chk("rst_mid_tx_data", tx_data, 0);
        n0 = nreq;
        run(40);
        chk("rst_mid_no_req", nreq - n0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
